// File: rtl/eq3_vector_tester.sv
// rtl/eq3_vector_tester.sv - self-running stimulus driver and checker for the 3-input all-equal function
module eq3_vector_tester #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask,
  output logic [2:0] vec_idx,
  output logic       sample_stb
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int CW = 8;
  // Last counter value spent in SETTLE; unused when the settle phase is skipped.
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] settle_cnt;
  logic          expected;

  // Reference value of the all-equal function for the vector currently on the DUT pins.
  assign expected   = ({dut_a, dut_b, dut_c} == 3'b000) || ({dut_a, dut_b, dut_c} == 3'b111);
  assign sample_stb = (state == SAMPLE);
  assign pass       = done && (err_count == 4'd0);

  // State register; reset abandons any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one vector per DRIVE -> SETTLE* -> SAMPLE pass.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        state_nxt = (vec_idx == 3'd7) ? DONE : DRIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: stimulus pins, settle counter and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      dut_c      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= 4'd0;
      fail_mask  <= 8'h00;
      vec_idx    <= 3'd0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_idx   <= 3'd0;
            err_count <= 4'd0;
            fail_mask <= 8'h00;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        DRIVE: begin
          {dut_a, dut_b, dut_c} <= vec_idx;
          settle_cnt            <= '0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
        end
        SAMPLE: begin
          if (dut_y != expected) begin
            err_count          <= err_count + 4'd1;
            fail_mask[vec_idx] <= 1'b1;
          end
          if (vec_idx == 3'd7) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            vec_idx <= vec_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
